// File: rtl/la_capture_engine_if.sv
// Dump stream between the capture engine (master) and a log sink (slave).
// Plain valid/ready handshake carrying one buffered sample per beat.
interface la_capture_engine_if #(
   parameter int PROBE_W = 48
);
   logic               log_valid;
   logic               log_ready;
   logic               log_last;
   logic [PROBE_W-1:0] log_data;

   modport master (
      output log_valid,
      output log_last,
      output log_data,
      input  log_ready
   );

   modport slave (
      input  log_valid,
      input  log_last,
      input  log_data,
      output log_ready
   );
endinterface

// File: rtl/la_capture_engine.sv
// Logic-analyzer capture engine: circular sample buffer with qualified trigger,
// post-trigger fill, then an in-order dump of the whole buffer over log.
module la_capture_engine #(
   parameter int PROBE_W = 48,
   parameter int DEPTH   = 256
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       cfg_arm,
   input  logic                       cfg_abort,
   input  logic [1:0]                 cfg_mode,
   input  logic [PROBE_W-1:0]         cfg_mask,
   input  logic [PROBE_W-1:0]         cfg_value,
   input  logic [$clog2(DEPTH)-1:0]   cfg_post,
   input  logic                       ext_trigger,
   input  logic [PROBE_W-1:0]         probe,
   la_capture_engine_if.master        log,
   output logic [1:0]                 status_state
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SAMPLE = 2'd1,
      S_POST   = 2'd2,
      S_DUMP   = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [PROBE_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [AW-1:0]      r_pre_cnt;
   logic [AW-1:0]      r_post_left;
   logic [AW-1:0]      r_beat_cnt;
   logic               r_prev_match;
   logic [1:0]         r_mode;
   logic [PROBE_W-1:0] r_mask;
   logic [PROBE_W-1:0] r_value;
   logic [AW-1:0]      r_post;

   logic               w_match;
   logic               w_hit;
   logic               w_qual;
   logic               w_write;
   logic               w_last;
   logic               w_beat_done;
   logic [AW-1:0]      w_pre_req;

   assign w_write     = (r_state == S_SAMPLE) || (r_state == S_POST);
   assign w_match     = ((probe ^ r_value) & r_mask) == '0;
   assign w_pre_req   = AW'(DEPTH - 1) - r_post;
   assign w_last      = (r_beat_cnt == AW'(DEPTH - 1));
   assign w_beat_done = (r_state == S_DUMP) && log.log_ready;

   always_comb begin
      w_hit = 1'b0;
      case (r_mode)
         2'd0:    w_hit = w_match;
         2'd1:    w_hit = w_match && !r_prev_match;
         2'd2:    w_hit = 1'b1;
         default: w_hit = ext_trigger;
      endcase
   end

   // Hits before enough pre-trigger history exists are dropped on the floor.
   assign w_qual = w_hit && (r_pre_cnt >= w_pre_req);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state  = r_state;
      log.log_valid = 1'b0;
      log.log_last  = 1'b0;
      log.log_data  = r_mem[r_rd_ptr];
      case (r_state)
         S_IDLE:   if (cfg_arm) w_next_state = S_SAMPLE;
         S_SAMPLE: if (w_qual) w_next_state = (r_post == '0) ? S_DUMP : S_POST;
         S_POST:   if (r_post_left == AW'(1)) w_next_state = S_DUMP;
         S_DUMP: begin
            log.log_valid = 1'b1;
            log.log_last  = w_last;
            if (w_beat_done && w_last) w_next_state = S_IDLE;
         end
         default: ;
      endcase
      if (cfg_abort) w_next_state = S_IDLE;
   end

   // Sample storage carries no reset so it can map onto plain RAM.
   always_ff @(posedge clk) begin
      if (w_write) r_mem[r_wr_ptr] <= probe;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_pre_cnt    <= '0;
         r_post_left  <= '0;
         r_beat_cnt   <= '0;
         r_prev_match <= 1'b1;
         r_mode       <= '0;
         r_mask       <= '0;
         r_value      <= '0;
         r_post       <= '0;
      end else begin
         if (w_write) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (!cfg_abort) begin
            case (r_state)
               S_IDLE: begin
                  if (cfg_arm) begin
                     r_mode       <= cfg_mode;
                     r_mask       <= cfg_mask;
                     r_value      <= cfg_value;
                     r_post       <= cfg_post;
                     r_pre_cnt    <= '0;
                     r_prev_match <= 1'b1;
                  end
               end
               S_SAMPLE: begin
                  r_prev_match <= w_match;
                  if (r_pre_cnt != AW'(DEPTH - 1)) r_pre_cnt <= r_pre_cnt + AW'(1);
                  if (w_qual) begin
                     r_post_left <= r_post;
                     r_rd_ptr    <= r_wr_ptr + AW'(1);
                     r_beat_cnt  <= '0;
                  end
               end
               S_POST: begin
                  r_post_left <= r_post_left - AW'(1);
                  // Oldest sample sits just past the final write.
                  if (r_post_left == AW'(1)) begin
                     r_rd_ptr   <= r_wr_ptr + AW'(1);
                     r_beat_cnt <= '0;
                  end
               end
               S_DUMP: begin
                  if (w_beat_done) begin
                     r_rd_ptr   <= r_rd_ptr + AW'(1);
                     r_beat_cnt <= r_beat_cnt + AW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign status_state = r_state;
endmodule

// File: tb/tb_la_capture_engine.sv
// Bench for la_capture_engine (DEPTH=8, PROBE_W=16): vector table, corner
// sequences and random traffic against a sample-history reference model.
module tb_la_capture_engine;
   localparam int PW    = 16;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_arm, cfg_abort, ext_trigger;
   logic [1:0]    cfg_mode;
   logic [PW-1:0] cfg_mask, cfg_value, probe;
   logic [2:0]    cfg_post;
   logic [1:0]    status_state;

   la_capture_engine_if #(.PROBE_W(PW)) lif ();

   la_capture_engine #(.PROBE_W(PW), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (rst_n),
      .cfg_arm      (cfg_arm),
      .cfg_abort    (cfg_abort),
      .cfg_mode     (cfg_mode),
      .cfg_mask     (cfg_mask),
      .cfg_value    (cfg_value),
      .cfg_post     (cfg_post),
      .ext_trigger  (ext_trigger),
      .probe        (probe),
      .log          (lif),
      .status_state (status_state)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   function automatic void chk(input string name, input int act, input int exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: phase, history of samples written this capture, dump copy.
   int            m_phase;
   logic [PW-1:0] m_hist[$];
   logic [PW-1:0] m_dump[$];
   int            m_beat, m_left;
   bit            m_prev;
   logic [1:0]    m_mode;
   logic [PW-1:0] m_mask, m_value;
   int            m_post;

   function automatic void model_reset();
      m_phase = 0; m_hist.delete(); m_dump.delete();
      m_beat = 0; m_left = 0; m_prev = 1'b1;
   endfunction

   function automatic void push_sample();
      m_hist.push_back(probe);
      if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
   endfunction

   function automatic void enter_dump();
      m_dump = m_hist; m_beat = 0; m_phase = 3;
   endfunction

   function automatic void model_step();
      bit match, hit, qual;
      if (cfg_abort) begin
         m_phase = 0;
         return;
      end
      case (m_phase)
         0: if (cfg_arm) begin
               m_mode = cfg_mode; m_mask = cfg_mask; m_value = cfg_value;
               m_post = int'(cfg_post); m_hist.delete(); m_prev = 1'b1; m_phase = 1;
            end
         1: begin
               match = ((probe ^ m_value) & m_mask) == 0;
               case (m_mode)
                  2'd0: hit = match;
                  2'd1: hit = match && !m_prev;
                  2'd2: hit = 1'b1;
                  default: hit = ext_trigger;
               endcase
               qual = hit && (m_hist.size() >= DEPTH - 1 - m_post);
               m_prev = match;
               push_sample();
               if (qual) begin
                  if (m_post == 0) enter_dump();
                  else begin m_left = m_post; m_phase = 2; end
               end
            end
         2: begin
               push_sample();
               m_left--;
               if (m_left == 0) enter_dump();
            end
         default: if (lif.log_ready) begin
               m_beat++;
               if (m_beat == DEPTH) m_phase = 0;
            end
      endcase
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk); #1;
      chk("state", int'(status_state), m_phase);
      chk("valid", int'(lif.log_valid), int'(m_phase == 3));
      chk("last", int'(lif.log_last), int'(m_phase == 3 && m_beat == DEPTH - 1));
      if (m_phase == 3) chk("data", int'(lif.log_data), int'(m_dump[m_beat]));
   endtask

   task automatic run_capture(input logic [1:0] mode, input logic [PW-1:0] mask,
                              input logic [PW-1:0] value, input logic [2:0] post,
                              input int ext_at, input int limit, output bit reached);
      cfg_mode = mode; cfg_mask = mask; cfg_value = value; cfg_post = post;
      cfg_arm = 1'b1; tick(); cfg_arm = 1'b0;
      // Hostile live config: must be ignored once latched.
      cfg_mode = 2'd2; cfg_mask = '0; cfg_value = 16'hFFFF; cfg_post = 3'd0;
      reached = 1'b0;
      for (int i = 0; i < limit && !reached; i++) begin
         probe = PW'(i); ext_trigger = (i == ext_at);
         tick();
         if (status_state == 2'd3) reached = 1'b1;
      end
      ext_trigger = 1'b0;
   endtask

   task automatic collect(input int first, input int stall_beat, input int stall_len);
      lif.log_ready = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         if (k == stall_beat) begin
            lif.log_ready = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               tick();
               chk("stall_valid", int'(lif.log_valid), 1);
               chk("stall_data", int'(lif.log_data), first + k);
            end
            lif.log_ready = 1'b1;
         end
         chk("beat_data", int'(lif.log_data), first + k);
         chk("beat_last", int'(lif.log_last), int'(k == DEPTH - 1));
         tick();
      end
      chk("back_idle", int'(status_state), 0);
   endtask

   typedef struct {
      logic [1:0]    mode;
      logic [PW-1:0] mask;
      logic [PW-1:0] value;
      logic [2:0]    post;
      int            ext_at;
      int            first;   // expected beat-0 data, -1 = never triggers
   } vec_t;

   vec_t vecs[7];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit reached;
      logic [PW-1:0] edge_exp[DEPTH];

      vecs[0] = '{2'd0, 16'hFFFF, 16'h0010, 3'd3, -1, 12};
      vecs[1] = '{2'd0, 16'hFFFF, 16'h0002, 3'd3, -1, -1};
      vecs[2] = '{2'd2, 16'h0000, 16'h0000, 3'd0, -1, 0};
      vecs[3] = '{2'd2, 16'h0000, 16'h0000, 3'd7, -1, 0};
      vecs[4] = '{2'd0, 16'h000F, 16'h0003, 3'd2, -1, 14};
      vecs[5] = '{2'd1, 16'h0001, 16'h0001, 3'd4, -1, 0};
      vecs[6] = '{2'd3, 16'hFFFF, 16'hFFFF, 3'd1, 10, 4};

      rst_n = 1'b0; cfg_arm = 1'b0; cfg_abort = 1'b0; ext_trigger = 1'b0;
      cfg_mode = '0; cfg_mask = '0; cfg_value = '0; cfg_post = '0; probe = '0;
      lif.log_ready = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", int'(status_state), 0);
      chk("rst_valid", int'(lif.log_valid), 0);
      chk("rst_last", int'(lif.log_last), 0);
      rst_n = 1'b1;
      tick();

      foreach (vecs[v]) begin
         run_capture(vecs[v].mode, vecs[v].mask, vecs[v].value, vecs[v].post,
                     vecs[v].ext_at, (vecs[v].first < 0) ? 40 : 60, reached);
         if (vecs[v].first < 0) begin
            chk("no_trig_state", int'(status_state), 1);
            cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
         end else begin
            chk("trig_reached", int'(reached), 1);
            if (reached) collect(vecs[v].first, -1, 0);
            else begin cfg_abort = 1'b1; tick(); cfg_abort = 1'b0; end
         end
      end

      // Edge mode: a held match must not fire; a 0 -> match transition must.
      cfg_mode = 2'd1; cfg_mask = 16'h000F; cfg_value = 16'h0005; cfg_post = 3'd3;
      cfg_arm = 1'b1; tick(); cfg_arm = 1'b0;
      probe = 16'h0005;
      repeat (10) tick();
      chk("edge_held", int'(status_state), 1);
      probe = 16'h0000; tick();
      probe = 16'h0005; tick();
      chk("edge_fire", int'(status_state), 2);
      for (int j = 1; j <= 3; j++) begin probe = 16'h0100 + PW'(j); tick(); end
      chk("edge_dump", int'(status_state), 3);
      edge_exp = '{16'h5, 16'h5, 16'h5, 16'h0, 16'h5, 16'h101, 16'h102, 16'h103};
      for (int k = 0; k < DEPTH; k++) begin
         chk("edge_beat", int'(lif.log_data), int'(edge_exp[k]));
         tick();
      end

      // Backpressure at beat 3.
      run_capture(2'd2, '0, '0, 3'd0, -1, 60, reached);
      chk("bp_reached", int'(reached), 1);
      collect(0, 3, 5);

      // Abort together with arm mid-dump.
      run_capture(2'd2, '0, '0, 3'd0, -1, 60, reached);
      tick(); tick();
      chk("ab_beat2", int'(lif.log_data), 2);
      cfg_mode = 2'd2; cfg_post = 3'd0; cfg_arm = 1'b1; cfg_abort = 1'b1;
      tick();
      cfg_arm = 1'b0; cfg_abort = 1'b0;
      chk("ab_state", int'(status_state), 0);
      chk("ab_valid", int'(lif.log_valid), 0);
      tick();
      chk("ab_arm_ignored", int'(status_state), 0);

      // Asynchronous reset in the middle of POST.
      cfg_mode = 2'd2; cfg_post = 3'd5; cfg_arm = 1'b1; tick(); cfg_arm = 1'b0;
      for (int i = 0; i < 4; i++) begin probe = PW'(i); tick(); end
      chk("pre_rst_post", int'(status_state), 2);
      rst_n = 1'b0;
      #2;
      chk("arst_state", int'(status_state), 0);
      chk("arst_valid", int'(lif.log_valid), 0);
      chk("arst_last", int'(lif.log_last), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      tick();

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         cfg_mode  = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: cfg_mask = 16'hFFFF;
            1: cfg_mask = 16'h000F;
            2: cfg_mask = 16'h0003;
            default: cfg_mask = 16'h0000;
         endcase
         cfg_value     = PW'($urandom_range(0, 15));
         cfg_post      = 3'($urandom_range(0, 7));
         cfg_arm       = ($urandom_range(0, 3) == 0);
         cfg_abort     = ($urandom_range(0, 199) == 0);
         ext_trigger   = ($urandom_range(0, 7) == 0);
         probe         = PW'($urandom_range(0, 15));
         lif.log_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
